// File: rtl/binary_to_bcd_pkg.sv
// Shared definitions for the sequential double-dabble converter:
// FSM encoding, digit-adjust constants and the elaboration-time range helper.
package binary_to_bcd_pkg;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_e;

    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_INC       = 4'd3;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic logic digits_sufficient(input int unsigned w, input int unsigned d);
        return (d <= 32'd19) && (pow10(d) > ((64'd1 << w) - 64'd1));
    endfunction

endpackage

// File: rtl/binary_to_bcd_digit_adjust.sv
// Double-dabble per-digit correction: a BCD digit of 5 or more gets 3 added
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust
    import binary_to_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Input never exceeds 9, so the sum stays within 4 bits.
    always_comb begin
        if (digit_i >= BCD_ADJ_THRESHOLD) begin
            digit_o = digit_i + BCD_ADJ_INC;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter (one bit per cycle) with a leading-zero
// blank mask; results are held in output registers between conversions.
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      value,
    input  logic                  start,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     CNT_LOAD  = CW'(WIDTH);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(1);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    if ((WIDTH < 4) || (WIDTH > 32)) begin : g_bad_width
        $fatal(1, "binary_to_bcd: WIDTH must be in 4..32");
    end
    if (!digits_sufficient(WIDTH, DIGITS)) begin : g_bad_digits
        $fatal(1, "binary_to_bcd: DIGITS too small for WIDTH");
    end

    bcd_state_e             state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [4*DIGITS-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]      blank_q, blank_d;
    logic                   done_q, done_d;

    logic [4*DIGITS-1:0]    adj_s;
    logic [4*DIGITS-1:0]    scratch_shift_s;
    logic [DIGITS-1:0]      blank_s;
    logic                   zero_run_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // Adjusted scratch shifted left, taking in the next operand bit.
    assign scratch_shift_s = {adj_s[4*DIGITS-2:0], shift_q[WIDTH-1]};

    // Leading-zero mask of the scratch value that becomes the result.
    always_comb begin
        blank_s    = '0;
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (scratch_shift_s[4*i +: 4] == 4'd0);
            blank_s[i] = zero_run_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        done_d    = 1'b0;
        case (state_q)
            BCD_IDLE: begin
                if (start) begin
                    shift_d   = value;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = BCD_SHIFT;
                end else begin
                    state_d   = BCD_IDLE;
                end
            end
            BCD_SHIFT: begin
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                scratch_d = scratch_shift_s;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = BCD_DONE;
                    bcd_d   = scratch_shift_s;
                    blank_d = blank_s;
                    done_d  = 1'b1;
                end else begin
                    state_d = BCD_SHIFT;
                end
            end
            BCD_DONE: begin
                state_d = BCD_IDLE;
            end
            default: begin
                state_d = BCD_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BCD_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
        end
    end

    assign ready = (state_q == BCD_IDLE);
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign blank = blank_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Randomized self-checking bench for binary_to_bcd (16/5 and 8/3 variants)
// against a decimal-arithmetic reference model.
module tb_binary_to_bcd;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic        start;
    logic        ready;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    logic [7:0]  value8;
    logic        start8;
    logic        ready8;
    logic        done8;
    logic [11:0] bcd8;
    logic [2:0]  blank8;

    int n_cmp;
    int n_err;
    logic [19:0] exp_last;

    binary_to_bcd #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .reset(reset), .value(value), .start(start),
        .ready(ready), .done(done), .bcd(bcd), .blank(blank)
    );

    binary_to_bcd #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .reset(reset), .value(value8), .start(start8),
        .ready(ready8), .done(done8), .bcd(bcd8), .blank(blank8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits by repeated division.
    function automatic logic [39:0] ref_bcd(input longint unsigned v, input int nd);
        logic [39:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
        return r;
    endfunction

    // Digit i is a leading zero exactly when the value is below 10^i.
    function automatic logic [9:0] ref_blank(input longint unsigned v, input int nd);
        logic [9:0] b;
        longint unsigned p;
        b = '0;
        p = 64'd10;
        for (int i = 1; i < nd; i++) begin
            b[i] = (v < p);
            p = p * 64'd10;
        end
        return b;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {63'd0, ready}, 64'd1);
    endtask

    task automatic convert(input logic [15:0] v);
        int lat;
        int rlow;
        wait_ready();
        value = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        value = 16'($urandom);
        lat = 1;
        rlow = 0;
        while (!done && lat < 40) begin
            if (!ready) rlow++;
            if (lat == 8) chk("bcd_stable", 64'(bcd), 64'(exp_last));
            @(negedge clk);
            lat++;
        end
        if (!ready) rlow++;
        chk("latency", 64'(lat), 64'd17);
        chk("ready_low", 64'(rlow), 64'd17);
        chk("bcd", 64'(bcd), 64'(ref_bcd(64'(v), 5)));
        chk("blank", 64'(blank), 64'(ref_blank(64'(v), 5)));
        exp_last = 20'(ref_bcd(64'(v), 5));
        @(negedge clk);
        chk("done_single", {63'd0, done}, 64'd0);
        chk("ready_back", {63'd0, ready}, 64'd1);
        chk("bcd_hold", 64'(bcd), 64'(exp_last));
    endtask

    task automatic convert8(input logic [7:0] v);
        int lat;
        value8 = v;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("latency8", 64'(lat), 64'd9);
        chk("bcd8", 64'(bcd8), 64'(ref_bcd(64'(v), 3)));
        chk("blank8", 64'(blank8), 64'(ref_blank(64'(v), 3)));
        @(negedge clk);
        chk("ready8_back", {63'd0, ready8}, 64'd1);
    endtask

    initial begin
        logic [15:0] dir_vals [8];
        logic [15:0] held_vals [3];
        int ndone;
        int acc;
        int dn;
        int last_c;

        n_cmp = 0;
        n_err = 0;
        exp_last = 20'd0;
        reset = 1'b1;
        start = 1'b0;
        value = 16'd0;
        start8 = 1'b0;
        value8 = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_bcd", 64'(bcd), 64'd0);
        chk("rst_blank", 64'(blank), 64'h1e);
        chk("rst_blank8", 64'(blank8), 64'h6);
        reset = 1'b0;
        @(negedge clk);

        dir_vals = '{16'd0, 16'd65535, 16'd1234, 16'd9, 16'd99, 16'd100, 16'd9999, 16'd10000};
        foreach (dir_vals[k]) convert(dir_vals[k]);

        // Start re-pulsed during SHIFT must be ignored.
        wait_ready();
        value = 16'd777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        value = 16'd42;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ndone++;
                chk("ignored_bcd", 64'(bcd), 64'h00777);
            end
            @(negedge clk);
        end
        chk("ignored_dones", 64'(ndone), 64'd1);
        exp_last = 20'h00777;

        // Reset in SHIFT cycle 8 discards the conversion immediately.
        wait_ready();
        value = 16'd500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready", {63'd0, ready}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_bcd", 64'(bcd), 64'd0);
        chk("midrst_blank", 64'(blank), 64'h1e);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(ndone), 64'd0);
        exp_last = 20'd0;
        convert(16'd500);

        // Start held high: back-to-back conversions every WIDTH+2 cycles.
        held_vals = '{16'd1, 16'd10, 16'd100};
        wait_ready();
        acc = 0;
        dn = 0;
        last_c = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) begin
                if (dn < 3) begin
                    chk("held_bcd", 64'(bcd), 64'(ref_bcd(64'(held_vals[dn]), 5)));
                    if (dn > 0) chk("held_spacing", 64'(c - last_c), 64'd18);
                end else begin
                    chk("held_extra_done", 64'd1, 64'd0);
                end
                last_c = c;
                dn++;
            end
            if (ready && acc < 3) begin
                value = held_vals[acc];
                start = 1'b1;
                acc++;
            end else if (acc == 3 && !ready) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_dones", 64'(dn), 64'd3);
        exp_last = 20'h00100;

        for (int r = 0; r < 20; r++) begin
            convert(16'($urandom_range(0, 65535)));
        end

        convert8(8'd255);
        convert8(8'd0);
        convert8(8'd99);
        convert8(8'd100);
        for (int r = 0; r < 6; r++) begin
            convert8(8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
